// File: rtl/r3_xfer_seq_if.sv
// Handshake bundle between the block-transfer sequencer, its requester and the reg-3 flags.
// The master side drives requests, flags and p_ack; the slave side (the sequencer) drives status.
interface r3_xfer_seq_if #(
    parameter int LENW = 9
);
    logic            start;
    logic            dir;
    logic [LENW-1:0] len;
    logic            abort;
    logic            ph_p_full;
    logic            hp_p_data_avail;
    logic            p_ack;
    logic            p_nmi;
    logic            busy;
    logic            done;
    logic            aborted;
    logic            spurious;
    logic [LENW-1:0] remaining;

    modport master (
        output start, dir, len, abort, ph_p_full, hp_p_data_avail, p_ack,
        input  p_nmi, busy, done, aborted, spurious, remaining
    );

    modport slave (
        input  start, dir, len, abort, ph_p_full, hp_p_data_avail, p_ack,
        output p_nmi, busy, done, aborted, spurious, remaining
    );
endinterface

// File: rtl/r3_xfer_seq.sv
// Block-transfer sequencer: raises p_nmi once per byte when the reg-3 flag allows it,
// counts serviced bytes down and reports completion, abort and stray acknowledges.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transfer; waiting for start
// HOLD     | GAP-cycle pause after an ack while the reg-3 flag catches up
// WAIT_RDY | sampling the direction-specific reg-3 flag
// NMI      | p_nmi asserted, waiting for the parasite's p_ack
// DONE     | last byte serviced; done pulses for this one cycle
module r3_xfer_seq #(
    parameter int GAP  = 2,
    parameter int LENW = 9
) (
    input  logic         h_phi2,
    input  logic         rst_b,
    r3_xfer_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOLD     = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_NMI      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]   GAP_LOAD  = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [LENW-1:0] LEN_FULL  = LENW'(256);
    localparam logic [LENW-1:0] LEN_ONE   = LENW'(1);

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic [LENW-1:0] remaining_q, remaining_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            p_nmi_q, p_nmi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            spurious_q, spurious_d;

    logic            rdy;
    logic            start_ok;
    logic            abort_ok;
    logic            ack_ok;

    always_comb begin
        rdy      = dir_q ? bus.hp_p_data_avail : ~bus.ph_p_full;
        start_ok = (state_q == S_IDLE) && bus.start && !bus.abort;
        abort_ok = (state_q != S_IDLE) && bus.abort;
        ack_ok   = (state_q == S_NMI) && bus.p_ack && !bus.abort;
    end

    always_ff @(posedge h_phi2 or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
            p_nmi_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
            p_nmi_q     <= p_nmi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            spurious_q  <= spurious_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_WAIT_RDY;
            end
            S_HOLD: begin
                if (bus.abort)            state_d = S_IDLE;
                else if (gap_cnt_q == '0) state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (bus.abort) state_d = S_IDLE;
                else if (rdy)  state_d = S_NMI;
            end
            S_NMI: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.p_ack) begin
                    if (remaining_q == LEN_ONE) state_d = S_DONE;
                    else if (GAP == 0)          state_d = S_WAIT_RDY;
                    else                        state_d = S_HOLD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dir_d       = dir_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        spurious_d  = spurious_q;

        if (start_ok) begin
            dir_d       = bus.dir;
            remaining_d = (bus.len == '0) ? LEN_FULL : bus.len;
            spurious_d  = 1'b0;
        end

        // Saturating decrement keeps remaining from wrapping on an unexpected count.
        if (ack_ok && (remaining_q != '0))
            remaining_d = remaining_q - LEN_ONE;

        if ((state_d == S_HOLD) && (state_q != S_HOLD))
            gap_cnt_d = GAP_LOAD;
        else if ((state_q == S_HOLD) && (gap_cnt_q != '0))
            gap_cnt_d = gap_cnt_q - GW'(1);

        // A stray ack is flagged even if it coincides with start, so it is never lost.
        if (bus.p_ack && !p_nmi_q)
            spurious_d = 1'b1;

        p_nmi_d   = (state_d == S_NMI);
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        aborted_d = abort_ok;
    end

    assign bus.p_nmi     = p_nmi_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.spurious  = spurious_q;
    assign bus.remaining = remaining_q;

endmodule

// File: doc/r3_xfer_seq.md
R3_XFER_SEQ -- requirements
Module: r3_xfer_seq

Interface
REQ-001 SHALL have parameter GAP, default 2: minimum h_phi2 cycles from an accepted p_ack to the next readiness sample, covering the one-cycle lag of the reg-3 host-side flag.
REQ-002 SHALL have parameter LENW, default 9: width of the length and remaining-count fields.
REQ-003 SHALL have port h_phi2, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_b, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a block transfer.
REQ-006 SHALL have port dir, input, 1: transfer direction, sampled with start; 0 = parasite-to-host (P->H), 1 = host-to-parasite (H->P).
REQ-007 SHALL have port len, input, LENW: byte count, sampled with start; 0 means 256.
REQ-008 SHALL have port abort, input, 1: cancels any transfer in progress.
REQ-009 SHALL have port ph_p_full, input, 1: reg-3 P->H flag; 1 = parasite may not write.
REQ-010 SHALL have port hp_p_data_avail, input, 1: reg-3 H->P flag; 1 = byte waiting for parasite.
REQ-011 SHALL have port p_ack, input, 1: one-cycle pulse; the parasite has serviced the NMI by accessing reg 3.
REQ-012 SHALL have port p_nmi, output, 1: NMI request to the parasite.
REQ-013 SHALL have port busy, output, 1: a transfer is in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-015 SHALL have port aborted, output, 1: one-cycle pulse when abort terminates a transfer.
REQ-016 SHALL have port spurious, output, 1: sticky error; a p_ack arrived while p_nmi was low.
REQ-017 SHALL have port remaining, output, LENW: bytes still to transfer.

Function
REQ-018 SHALL implement the states IDLE, HOLD, WAIT_RDY, NMI and DONE; all outputs are registered.
- REQ-019 IDLE: on start, SHALL latch dir, load remaining = (len==0 ? 256 : len), clear spurious, and enter WAIT_RDY; busy goes high on the same edge.
- REQ-020 WAIT_RDY: the ready condition SHALL be (dir==0 and ph_p_full==0) or (dir==1 and hp_p_data_avail==1); when ready, the block enters NMI and p_nmi goes high on that same edge (one-cycle latency from ready).
- REQ-021 NMI: p_nmi SHALL stay high until p_ack. On p_ack, p_nmi drops on the same edge and remaining decrements by 1. If the new remaining is 0, the block enters DONE; otherwise it enters HOLD.
- REQ-022 HOLD: SHALL wait exactly GAP cycles, ignoring the flags, then enter WAIT_RDY; GAP=0 goes directly to WAIT_RDY.
- REQ-023 DONE: SHALL pulse done for one cycle, clear busy, and return to IDLE. remaining reads 0.
REQ-024 start while busy SHALL be ignored; latched dir and remaining are unchanged.
REQ-025 p_ack in any state other than NMI SHALL set spurious and SHALL NOT change remaining or the state.
REQ-026 abort in any non-IDLE state SHALL, on the next edge: go to IDLE, drop p_nmi, clear busy, pulse aborted, and hold remaining at its value; done SHALL NOT pulse.
REQ-027 abort in IDLE SHALL have no effect; abort together with start in IDLE SHALL leave the block in IDLE.
REQ-028 abort together with p_ack in NMI SHALL give priority to abort; remaining SHALL NOT decrement.
REQ-029 Readiness SHALL be sampled only in WAIT_RDY; flag changes in other states have no effect.
REQ-030 remaining SHALL never underflow; arithmetic is unsigned LENW-bit.

Reset
REQ-031 rst_b low SHALL force, asynchronously: IDLE, p_nmi=0, busy=0, done=0, aborted=0, spurious=0, remaining=0.
REQ-032 Reset mid-transfer SHALL discard the transfer with no done or aborted pulse; operation resumes on the first edge after rst_b rises.

Verification
REQ-033 P->H, len=3, GAP=2, ph_p_full=0, p_ack 2 cycles after each p_nmi -> exactly 3 p_nmi pulses, remaining goes 3,2,1,0, one done pulse, busy low afterwards.
REQ-034 H->P, len=0, hp_p_data_avail toggled -> 256 NMIs, each only while the flag is 1; done once after the 256th p_ack.
REQ-035 abort asserted on the same edge as p_ack with remaining=5 -> aborted pulse, remaining stays 5, p_nmi=0, no done.
REQ-036 p_ack in IDLE, then start -> spurious=1 after the p_ack and 0 after the start edge.
REQ-037 start while busy with len=7 -> ignored; the original count completes.
REQ-038 rst_b low during NMI -> p_nmi=0 and remaining=0 immediately, without waiting for a clock edge.
